// File: rtl/sha2_compress.sv
// sha2_compress: SHA-256 / SHA-512 compression engine.
// One block per transaction, one round per clock, feed-forward add.
module sha2_compress #(
  parameter int WORDSIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*WORDSIZE-1:0]   H_in,
  input  logic [16*WORDSIZE-1:0]  M_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [8*WORDSIZE-1:0]   H_out,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [6:0]              round_idx
);

  localparam int ROUNDS = (WORDSIZE == 32) ? 64 : 80;
  localparam logic [6:0] LAST = 7'(ROUNDS - 1);

  if (WORDSIZE != 32 && WORDSIZE != 64) begin : g_bad_ws
    $error("sha2_compress: WORDSIZE must be 32 or 64");
  end

  typedef logic [WORDSIZE-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    ADD,
    DONE
  } state_t;

  // SHA-512 round constants; the 32-bit engine takes the upper halves,
  // which are exactly the SHA-256 constants.
  localparam logic [63:0] K [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd,
    64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019,
    64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe,
    64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1,
    64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3,
    64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483,
    64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210,
    64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725,
    64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926,
    64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8,
    64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001,
    64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910,
    64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53,
    64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb,
    64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60,
    64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9,
    64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207,
    64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6,
    64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493,
    64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a,
    64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  function automatic word_t rotr(word_t x, int n);
    return (x >> n) | (x << (WORDSIZE - n));
  endfunction

  function automatic word_t bsig0(word_t x);
    if (WORDSIZE == 32)
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    else
      return rotr(x, 28) ^ rotr(x, 34) ^ rotr(x, 39);
  endfunction

  function automatic word_t bsig1(word_t x);
    if (WORDSIZE == 32)
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    else
      return rotr(x, 14) ^ rotr(x, 18) ^ rotr(x, 41);
  endfunction

  function automatic word_t ssig0(word_t x);
    if (WORDSIZE == 32)
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    else
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
  endfunction

  function automatic word_t ssig1(word_t x);
    if (WORDSIZE == 32)
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    else
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
  endfunction

  state_t state;
  word_t  st [8];
  word_t  hv [8];
  word_t  w  [16];
  word_t  kt;
  word_t  ch;
  word_t  maj;
  word_t  t1;
  word_t  t2;
  word_t  w_new;

  // Round datapath and next schedule word; w[0] is always W[t].
  always_comb begin
    kt    = K[round_idx][63 -: WORDSIZE];
    ch    = (st[4] & st[5]) ^ (~st[4] & st[6]);
    maj   = (st[0] & st[1]) ^ (st[0] & st[2]) ^ (st[1] & st[2]);
    t1    = st[7] + bsig1(st[4]) + ch + kt + w[0];
    t2    = bsig0(st[0]) + maj;
    w_new = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
  end

  // Control FSM with working state, schedule window and outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      round_idx <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      H_out     <= '0;
      for (int i = 0; i < 8; i++) begin
        st[i] <= '0;
        hv[i] <= '0;
      end
      for (int i = 0; i < 16; i++) begin
        w[i] <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            for (int i = 0; i < 8; i++) begin
              hv[i] <= H_in[(7-i)*WORDSIZE +: WORDSIZE];
              st[i] <= H_in[(7-i)*WORDSIZE +: WORDSIZE];
            end
            for (int i = 0; i < 16; i++) begin
              w[i] <= M_in[(15-i)*WORDSIZE +: WORDSIZE];
            end
            round_idx <= '0;
            in_ready  <= 1'b0;
            state     <= ROUND;
          end
        end
        ROUND: begin
          st[0] <= t1 + t2;
          st[1] <= st[0];
          st[2] <= st[1];
          st[3] <= st[2];
          st[4] <= st[3] + t1;
          st[5] <= st[4];
          st[6] <= st[5];
          st[7] <= st[6];
          for (int i = 0; i < 15; i++) begin
            w[i] <= w[i+1];
          end
          w[15] <= w_new;
          if (round_idx == LAST) begin
            state <= ADD;
          end else begin
            round_idx <= round_idx + 7'd1;
          end
        end
        ADD: begin
          for (int i = 0; i < 8; i++) begin
            H_out[(7-i)*WORDSIZE +: WORDSIZE] <= hv[i] + st[i];
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            round_idx <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_compress.sv
// tb_sha2_compress: scoreboard bench for both SHA-256 and SHA-512 engines.
// Known-answer vectors plus random blocks against a plain SHA-2 model.
module tb_sha2_compress;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [255:0]  h32 = '0;
  logic [511:0]  m32 = '0;
  logic          iv32 = 1'b0;
  logic          ir32;
  logic [255:0]  ho32;
  logic          ov32;
  logic          or32 = 1'b1;
  logic [6:0]    ri32;

  logic [511:0]  h64 = '0;
  logic [1023:0] m64 = '0;
  logic          iv64 = 1'b0;
  logic          ir64;
  logic [511:0]  ho64;
  logic          ov64;
  logic          or64 = 1'b1;
  logic [6:0]    ri64;

  sha2_compress #(.WORDSIZE(32)) u256 (
    .clk(clk), .rst(rst),
    .H_in(h32), .M_in(m32),
    .in_valid(iv32), .in_ready(ir32),
    .H_out(ho32), .out_valid(ov32),
    .out_ready(or32), .round_idx(ri32)
  );

  sha2_compress #(.WORDSIZE(64)) u512 (
    .clk(clk), .rst(rst),
    .H_in(h64), .M_in(m64),
    .in_valid(iv64), .in_ready(ir64),
    .H_out(ho64), .out_valid(ov64),
    .out_ready(or64), .round_idx(ri64)
  );

  localparam logic [63:0] KT [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

  localparam logic [255:0] IV256 =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [511:0] ABC256 = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] KAT256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [511:0] IV512 = {
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam logic [1023:0] ABC512 = {64'h6162638000000000, 896'h0, 64'h18};
  localparam logic [511:0] KAT512 = {
    64'hddaf35a193617aba, 64'hcc417349ae204131, 64'h12e6fa4e89a97ea2, 64'h0a9eeee64b55d39a,
    64'h2192992a274fc1a8, 64'h36ba3c23a3feebbd, 64'h454d4423643ce80e, 64'h2a9ac94fa54ca49f};
  localparam logic [511:0] BLK1 = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK2 = {480'h0, 32'h000001c0};
  localparam logic [255:0] KAT2 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rr(logic [63:0] x, int n, int ws);
    logic [63:0] mk;
    mk = (ws == 32) ? 64'h00000000ffffffff : '1;
    return ((x >> n) | (x << (ws - n))) & mk;
  endfunction

  function automatic logic [63:0] bs0(logic [63:0] x, int ws);
    if (ws == 32) return rr(x, 2, ws) ^ rr(x, 13, ws) ^ rr(x, 22, ws);
    return rr(x, 28, ws) ^ rr(x, 34, ws) ^ rr(x, 39, ws);
  endfunction

  function automatic logic [63:0] bs1(logic [63:0] x, int ws);
    if (ws == 32) return rr(x, 6, ws) ^ rr(x, 11, ws) ^ rr(x, 25, ws);
    return rr(x, 14, ws) ^ rr(x, 18, ws) ^ rr(x, 41, ws);
  endfunction

  function automatic logic [63:0] ss0(logic [63:0] x, int ws);
    if (ws == 32) return rr(x, 7, ws) ^ rr(x, 18, ws) ^ (x >> 3);
    return rr(x, 1, ws) ^ rr(x, 8, ws) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] ss1(logic [63:0] x, int ws);
    if (ws == 32) return rr(x, 17, ws) ^ rr(x, 19, ws) ^ (x >> 10);
    return rr(x, 19, ws) ^ rr(x, 61, ws) ^ (x >> 6);
  endfunction

  // Full compression with an explicit expanded message schedule.
  function automatic logic [511:0] ref_compress(input int ws,
                                                input logic [511:0] hin,
                                                input logic [1023:0] min);
    logic [63:0] mk, t1, t2, k;
    logic [63:0] wt [80];
    logic [63:0] hh [8];
    logic [63:0] v [8];
    logic [511:0] r;
    int nr;
    mk = (ws == 32) ? 64'h00000000ffffffff : '1;
    nr = (ws == 32) ? 64 : 80;
    for (int i = 0; i < 16; i++) wt[i] = 64'(min >> ((15 - i) * ws)) & mk;
    for (int i = 16; i < 80; i++)
      wt[i] = (ss1(wt[i-2], ws) + wt[i-7] + ss0(wt[i-15], ws) + wt[i-16]) & mk;
    for (int i = 0; i < 8; i++) begin
      hh[i] = 64'(hin >> ((7 - i) * ws)) & mk;
      v[i] = hh[i];
    end
    for (int t = 0; t < nr; t++) begin
      k = (ws == 32) ? (KT[t] >> 32) : KT[t];
      t1 = (v[7] + bs1(v[4], ws) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + wt[t]) & mk;
      t2 = (bs0(v[0], ws) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]))) & mk;
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4];
      v[4] = (v[3] + t1) & mk;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0];
      v[0] = (t1 + t2) & mk;
    end
    r = '0;
    for (int i = 0; i < 8; i++) r = (r << ws) | 512'((hh[i] + v[i]) & mk);
    return r;
  endfunction

  function automatic logic [1023:0] rnd();
    logic [1023:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r = {r[991:0], 32'($urandom())};
    return r;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  typedef struct {
    logic [511:0] dig;
    int           acc;
  } exp_t;

  exp_t q32[$];
  exp_t q64[$];

  int n_cmp = 0;
  int n_err = 0;
  int tmo_req = 0, tmo_done = 0;
  int rst_req = 0, rst_done = 0;
  int end_req = 0, end_done = 0;
  bit seen [2] = '{1'b0, 1'b0};
  bit prev_hs [2] = '{1'b0, 1'b0};
  logic [511:0] held [2];

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic mon(input int id, input logic ov, input logic ir,
                     input logic [511:0] ho, input logic ordy);
    exp_t e;
    int lat;
    lat = (id == 0) ? 65 : 81;
    if (prev_hs[id]) begin
      chk($sformatf("d%0d_in_ready_after_hs", id), 512'(ir), 512'(1));
      chk($sformatf("d%0d_out_valid_after_hs", id), 512'(ov), 512'(0));
      prev_hs[id] = 1'b0;
    end
    if (seen[id]) begin
      chk($sformatf("d%0d_out_valid_held", id), 512'(ov), 512'(1));
      chk($sformatf("d%0d_H_out_stable", id), ho, held[id]);
      chk($sformatf("d%0d_in_ready_low", id), 512'(ir), 512'(0));
    end else if (ov) begin
      seen[id] = 1'b1;
      held[id] = ho;
      if ((id == 0 ? q32.size() : q64.size()) == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL d%0d_unexpected_output got=%0h required=none", id, ho);
      end else begin
        e = (id == 0) ? q32.pop_front() : q64.pop_front();
        chk($sformatf("d%0d_digest", id), ho, e.dig);
        chk($sformatf("d%0d_latency", id), 512'(cyc - e.acc), 512'(lat));
        chk($sformatf("d%0d_in_ready_low", id), 512'(ir), 512'(0));
      end
    end
    if (ov && ordy) begin
      prev_hs[id] = 1'b1;
      seen[id] = 1'b0;
    end
  endtask

  // Sample everything on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        seen[i] = 1'b0;
        prev_hs[i] = 1'b0;
      end
    end else begin
      if (tmo_req != tmo_done) begin
        n_cmp++;
        n_err++;
        $display("FAIL timeout got=expired required=handshake (%0d)", tmo_req);
        tmo_done = tmo_req;
      end
      if (rst_req != rst_done) begin
        chk("rst_out_valid32", 512'(ov32), 512'(0));
        chk("rst_in_ready32", 512'(ir32), 512'(1));
        chk("rst_H_out32", {256'b0, ho32}, 512'(0));
        chk("rst_round_idx32", 512'(ri32), 512'(0));
        chk("rst_out_valid64", 512'(ov64), 512'(0));
        chk("rst_in_ready64", 512'(ir64), 512'(1));
        chk("rst_H_out64", ho64, 512'(0));
        chk("rst_round_idx64", 512'(ri64), 512'(0));
        rst_done = rst_req;
      end
      mon(0, ov32, ir32, {256'b0, ho32}, or32);
      mon(1, ov64, ir64, ho64, or64);
      if (end_req != end_done) begin
        chk("q32_drained", 512'(q32.size()), 512'(0));
        chk("q64_drained", 512'(q64.size()), 512'(0));
        end_done = end_req;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic rdy(input int id);
    return (id == 0) ? ir32 : ir64;
  endfunction

  function automatic logic ovl(input int id);
    return (id == 0) ? ov32 : ov64;
  endfunction

  task automatic wait_ready(input int id);
    int n;
    n = 0;
    while (!rdy(id) && n < 400) begin
      tick();
      n++;
    end
    if (!rdy(id)) tmo_req++;
  endtask

  task automatic wait_out(input int id);
    int n;
    n = 0;
    while (!ovl(id) && n < 400) begin
      tick();
      n++;
    end
    if (!ovl(id)) tmo_req++;
  endtask

  task automatic go(input int id, input logic [511:0] h,
                    input logic [1023:0] m, input logic [511:0] e);
    exp_t x;
    logic [1023:0] j;
    wait_ready(id);
    x.dig = e;
    x.acc = cyc + 1;
    if (id == 0) begin
      h32 = h[255:0]; m32 = m[511:0]; iv32 = 1'b1;
      q32.push_back(x);
    end else begin
      h64 = h; m64 = m; iv64 = 1'b1;
      q64.push_back(x);
    end
    tick();
    j = rnd();
    if (id == 0) begin
      iv32 = 1'b0; h32 = j[255:0]; m32 = j[1023:512];
    end else begin
      iv64 = 1'b0; h64 = j[511:0]; m64 = rnd();
    end
  endtask

  initial begin
    logic [1023:0] r1, r2;
    logic [511:0] mid;
    int n;
    #200000;
    $display("FAIL watchdog got=no_finish required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] r1;
    logic [1023:0] r2;
    logic [511:0] mid;
    int n;
    repeat (3) tick();
    rst = 1'b0;
    rst_req++;
    tick();

    go(0, {256'b0, IV256}, {512'b0, ABC256}, {256'b0, KAT256});
    wait_ready(0);
    go(1, IV512, ABC512, KAT512);
    wait_ready(1);

    mid = ref_compress(32, {256'b0, IV256}, {512'b0, BLK1});
    go(0, {256'b0, IV256}, {512'b0, BLK1}, mid);
    go(0, mid, {512'b0, BLK2}, {256'b0, KAT2});
    wait_ready(0);

    or64 = 1'b0;
    go(1, IV512, ABC512, KAT512);
    wait_out(1);
    for (int i = 0; i < 20; i++) begin
      r1 = rnd();
      iv64 = 1'($urandom_range(0, 1));
      h64 = r1[511:0];
      m64 = rnd();
      tick();
    end
    iv64 = 1'b0;
    or64 = 1'b1;
    wait_ready(1);

    go(0, {256'b0, IV256}, {512'b0, ABC256}, {256'b0, KAT256});
    n = 0;
    while (!ov32 && n < 200) begin
      r1 = rnd();
      h32 = r1[255:0];
      m32 = r1[767:256];
      iv32 = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    iv32 = 1'b0;
    wait_ready(0);

    for (int i = 0; i < 6; i++) begin
      r1 = rnd();
      r2 = rnd();
      go(0, {256'b0, r1[255:0]}, {512'b0, r2[511:0]},
         ref_compress(32, {256'b0, r1[255:0]}, {512'b0, r2[511:0]}));
      r1 = rnd();
      r2 = rnd();
      go(1, r1[511:0], r2, ref_compress(64, r1[511:0], r2));
    end
    wait_ready(0);
    wait_ready(1);

    go(0, {256'b0, IV256}, {512'b0, ABC256}, {256'b0, KAT256});
    go(1, IV512, ABC512, KAT512);
    n = 0;
    while (ri64 != 7'd30 && n < 200) begin
      tick();
      n++;
    end
    if (ri64 != 7'd30) tmo_req++;
    rst = 1'b1;
    q32.delete();
    q64.delete();
    tick();
    tick();
    rst = 1'b0;
    rst_req++;
    tick();
    go(1, IV512, ABC512, KAT512);
    go(0, {256'b0, IV256}, {512'b0, ABC256}, {256'b0, KAT256});
    wait_ready(0);
    wait_ready(1);

    end_req++;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
